seq_to_stream: RTL and testbench

//  Inverse neighbour of the stream-to-sequential converter. Placed at the regfile read side.

---
 rtl/seq_to_stream_if.sv | 31 +++
 rtl/seq_to_stream.sv | 139 +++++++++++++
 tb/tb_seq_to_stream.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_to_stream_if.sv
// seq_to_stream_if: bus bundle for seq_to_stream.
//   in_data  : staggered chunked input word (chunk c = coefs [c*IN_NB/SEQ +: IN_NB/SEQ])
//   in_vld   : per-coefficient valid of the chunked input
//   in_rdy   : per-coefficient ready (chunk 0 = slot free, later chunks always 1)
//   out_data : reassembled word
//   out_vld  : stream valid
//   out_rdy  : stream ready
//   seq_err  : one-cycle pulse on a chunk sequencing violation
// master = producer/consumer side (drives input chunks and out_rdy), slave = seq_to_stream.
interface seq_to_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN_NB = 8
);
    logic [IN_NB*WIDTH-1:0] in_data;
    logic [IN_NB-1:0]       in_vld;
    logic [IN_NB-1:0]       in_rdy;
    logic [IN_NB*WIDTH-1:0] out_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   seq_err;

    modport master (
        output in_data, in_vld, out_rdy,
        input  in_rdy, out_data, out_vld, seq_err
    );

    modport slave (
        input  in_data, in_vld, out_rdy,
        output in_rdy, out_data, out_vld, seq_err
    );
endinterface

// File: rtl/seq_to_stream.sv
// seq_to_stream: collects words arriving as SEQ staggered chunks (chunk k exactly k cycles
// after chunk 0), buffers up to DEPTH complete words and re-emits each as one rdy/vld beat.
// Ports:
//   clk      : clock
//   a_rst_n  : asynchronous active-low reset
//   bus      : seq_to_stream_if.slave (in_data/in_vld/in_rdy chunked input,
//              out_data/out_vld/out_rdy stream output, seq_err violation pulse)
// Chunks 1..SEQ-1 cannot be stalled, so a slot is reserved as soon as chunk 0 is accepted
// and a tracker shift register tells each later chunk which slot it belongs to.
module seq_to_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN_NB = 8,
    parameter int unsigned SEQ   = 2,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            a_rst_n,
    seq_to_stream_if.slave bus
);
    localparam int unsigned CW  = IN_NB / SEQ;        // coefficients per chunk
    localparam int unsigned CDW = CW * WIDTH;         // bits per chunk
    localparam int unsigned DW  = IN_NB * WIDTH;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned TRK = (SEQ > 1) ? SEQ - 1 : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    if (IN_NB % SEQ != 0) begin : g_bad_seq
        $fatal(1, "seq_to_stream: SEQ must divide IN_NB");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "seq_to_stream: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   rsv_q, rsv_d;       // slots reserved (accepted, not yet popped)
    logic [AW:0]   cmp_q, cmp_d;       // slots fully written, not yet popped
    logic [TRK-1:0] trk_vld_q, trk_vld_d;
    logic [AW-1:0]  trk_slot_q [TRK];
    logic [AW-1:0]  trk_slot_d [TRK];
    logic           seq_err_q, seq_err_d;

    logic [DW-1:0]  mem_q [DEPTH];

    logic [SEQ-1:0] chunk_vld;
    logic           rdy0;
    logic           acc;
    logic           pop;
    logic           done;

    // Ready depends only on the registered count: a pop while full frees the slot next cycle.
    assign rdy0         = rsv_q < FULL;
    assign bus.out_vld  = cmp_q != '0;
    assign bus.out_data = mem_q[rd_ptr_q];
    assign bus.seq_err  = seq_err_q;

    always_comb begin
        bus.in_rdy         = '1;
        bus.in_rdy[CW-1:0] = {CW{rdy0}};
    end

    always_comb begin
        chunk_vld = '0;
        for (int unsigned k = 0; k < SEQ; k++) begin
            chunk_vld[k] = bus.in_vld[k*CW];
        end

        acc  = chunk_vld[0] & rdy0;
        pop  = (cmp_q != '0) & bus.out_rdy;
        // A slot completes when its last chunk is due, whether or not that chunk showed up.
        done = (SEQ == 1) ? acc : trk_vld_q[TRK-1];

        wr_ptr_d = wr_ptr_q + AW'(acc);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        rsv_d    = rsv_q + (AW+1)'(acc) - (AW+1)'(pop);
        cmp_d    = cmp_q + (AW+1)'(done) - (AW+1)'(pop);

        trk_vld_d     = '0;
        trk_vld_d[0]  = acc;
        trk_slot_d[0] = wr_ptr_q;
        for (int unsigned j = 1; j < TRK; j++) begin
            trk_vld_d[j]  = trk_vld_q[j-1];
            trk_slot_d[j] = trk_slot_q[j-1];
        end

        // Chunk k must arrive exactly when tracker stage k-1 holds a slot.
        seq_err_d = 1'b0;
        for (int unsigned k = 1; k < SEQ; k++) begin
            if (chunk_vld[k] != trk_vld_q[k-1]) begin
                seq_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rsv_q     <= '0;
            cmp_q     <= '0;
            trk_vld_q <= '0;
            for (int unsigned j = 0; j < TRK; j++) begin
                trk_slot_q[j] <= '0;
            end
            seq_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rsv_q     <= rsv_d;
            cmp_q     <= cmp_d;
            trk_vld_q <= trk_vld_d;
            for (int unsigned j = 0; j < TRK; j++) begin
                trk_slot_q[j] <= trk_slot_d[j];
            end
            seq_err_q <= seq_err_d;
        end
    end

    // Slot storage carries no reset; a dropped late chunk leaves the slot chunk stale.
    always_ff @(posedge clk) begin
        if (acc) begin
            mem_q[wr_ptr_q][0 +: CDW] <= bus.in_data[0 +: CDW];
        end
        for (int unsigned k = 1; k < SEQ; k++) begin
            if (chunk_vld[k] && trk_vld_q[k-1]) begin
                mem_q[trk_slot_q[k-1]][k*CDW +: CDW] <= bus.in_data[k*CDW +: CDW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst_n) begin
            for (int unsigned k = 0; k < SEQ; k++) begin
                assert (bus.in_vld[k*CW +: CW] == {CW{bus.in_vld[k*CW]}})
                    else $error("seq_to_stream: in_vld bits of chunk %0d disagree", k);
            end
        end
    end
endmodule

// File: tb/tb_seq_to_stream.sv
module tb_seq_to_stream;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IN_NB = 8;
    localparam int unsigned SEQ   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = IN_NB * WIDTH;
    localparam int unsigned HW    = DW / 2;
    localparam int unsigned CW    = IN_NB / 2;

    logic clk = 1'b0;
    logic a_rst_n;
    always #5 clk = ~clk;

    seq_to_stream_if #(.WIDTH(WIDTH), .IN_NB(IN_NB)) bus ();

    seq_to_stream #(.WIDTH(WIDTH), .IN_NB(IN_NB), .SEQ(SEQ), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: FIFO of accepted words with the cycle each becomes visible.
    logic [DW-1:0] mq_data [$];
    int            mq_due  [$];
    bit            trk_prev;
    bit            err_next;
    logic [HW-1:0] prev_hi;

    logic          o_rdy0, o_vld, o_err, e_rdy0, e_vld, e_err;
    logic [DW-1:0] o_data, e_data;
    bit            last_acc;
    int            obs_cyc;

    task automatic model_reset();
        mq_data.delete();
        mq_due.delete();
        trk_prev = 1'b0;
        err_next = 1'b0;
    endtask

    // Drives one cycle. c1mode: 0 = chunk 1 follows an accepted chunk 0, 1 = suppress it,
    // 2 = inject a spurious chunk 1. Called at posedge+1, returns at the next posedge+1.
    task automatic drive_cycle(input bit v0, input logic [DW-1:0] word, input int c1mode,
                               input bit ordy);
        bit c1v;
        logic [HW-1:0] c1d;
        bit acc, pop;
        c1v = (c1mode == 0) ? trk_prev : (c1mode == 2);
        c1d = (c1mode == 2) ? HW'($urandom) : prev_hi;
        bus.in_vld  = {{CW{c1v}}, {CW{v0}}};
        bus.in_data = {c1d, word[HW-1:0]};
        bus.out_rdy = ordy;
        @(negedge clk);
        e_rdy0 = (mq_data.size() < DEPTH);
        e_vld  = (mq_data.size() > 0) && (mq_due[0] <= cyc);
        e_data = e_vld ? mq_data[0] : '0;
        e_err  = err_next;
        o_rdy0 = bus.in_rdy[0];
        o_vld  = bus.out_vld;
        o_data = bus.out_data;
        o_err  = bus.seq_err;
        obs_cyc = cyc;
        acc = v0 && e_rdy0;
        pop = e_vld && ordy;
        err_next = (c1v != trk_prev);
        if (pop) begin
            void'(mq_data.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_data.push_back(word);
            mq_due.push_back(cyc + SEQ);
        end
        trk_prev = acc;
        prev_hi  = word[DW-1:HW];
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        a_rst_n     = 1'b0;
        bus.in_vld  = '0;
        bus.in_data = '0;
        bus.out_rdy = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.in_rdy !== '1) begin
            errors++; $display("FAIL reset_in_rdy got %b required all ones", bus.in_rdy);
        end
        checks++;
        if ({bus.out_vld, bus.seq_err} !== 2'b00) begin
            errors++; $display("FAIL reset_vld_err got %b required 00", {bus.out_vld, bus.seq_err});
        end
        #9 a_rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        int t0, first, beats;
        w = {32'h2222_2222, 32'h1111_1111};
        t0 = cyc; first = -1; beats = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i == 0, w, 0, 1'b1);
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL single_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
            if (o_vld === 1'b1) begin
                beats++;
                if (first < 0) first = obs_cyc;
                checks++;
                if (o_data !== w) begin
                    errors++; $display("FAIL single_data got %h required %h", o_data, w);
                end
            end
        end
        checks++;
        if (first != t0 + 2) begin
            errors++; $display("FAIL single_latency got cycle %0d required %0d", first, t0 + 2);
        end
        checks++;
        if (beats != 1) begin
            errors++; $display("FAIL single_beats got %0d required 1", beats);
        end
    endtask

    task automatic test_back_to_back();
        int beats, drops;
        beats = 0; drops = 0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i < 8, {$urandom, $urandom}, 0, 1'b1);
            if (i < 8 && o_rdy0 !== 1'b1) drops++;
            if (o_vld === 1'b1) beats++;
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL b2b_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
            if (e_vld) begin
                checks++;
                if (o_data !== e_data) begin
                    errors++; $display("FAIL b2b_data cyc=%0d got %h required %h", obs_cyc, o_data, e_data);
                end
            end
        end
        checks++;
        if (beats != 8 || drops != 0) begin
            errors++; $display("FAIL b2b_count got beats=%0d drops=%0d required beats=8 drops=0", beats, drops);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] words [6];
        int idx, beats, n;
        for (int i = 0; i < 6; i++) words[i] = {$urandom, $urandom};
        idx = 0; beats = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(idx < 6, words[idx % 6], 0, 1'b0);
            if (last_acc) idx++;
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL fill_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
        end
        checks++;
        if (idx != 4 || o_rdy0 !== 1'b0) begin
            errors++; $display("FAIL fill_stop got accepted=%0d rdy=%b required 4 and 0", idx, o_rdy0);
        end
        n = 0;
        while ((idx < 6 || mq_data.size() > 0) && n < 40) begin
            drive_cycle(idx < 6, words[idx % 6], 0, 1'b1);
            if (last_acc) idx++;
            if (o_vld === 1'b1) beats++;
            n++;
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL fill_drain_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
            if (e_vld) begin
                checks++;
                if (o_data !== e_data) begin
                    errors++; $display("FAIL fill_data cyc=%0d got %h required %h", obs_cyc, o_data, e_data);
                end
            end
        end
        checks++;
        if (idx != 6 || beats != 6) begin
            errors++; $display("FAIL fill_total got accepted=%0d beats=%0d required 6 and 6", idx, beats);
        end
    endtask

    task automatic test_pop_full();
        for (int i = 0; i < 7; i++) begin
            drive_cycle(i < 4, {$urandom, $urandom}, 0, 1'b0);
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL popfull_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
        end
        drive_cycle(1'b0, '0, 0, 1'b1);
        checks++;
        if (o_rdy0 !== 1'b0 || o_vld !== 1'b1) begin
            errors++; $display("FAIL popfull_same_cycle got rdy=%b vld=%b required rdy=0 vld=1", o_rdy0, o_vld);
        end
        drive_cycle(1'b0, '0, 0, 1'b0);
        checks++;
        if (o_rdy0 !== 1'b1) begin
            errors++; $display("FAIL popfull_next_cycle got rdy=%b required 1", o_rdy0);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, '0, 0, 1'b1);
            if (e_vld) begin
                checks++;
                if (o_vld !== 1'b1 || o_data !== e_data) begin
                    errors++; $display("FAIL popfull_drain cyc=%0d got vld=%b data=%h required 1 %h",
                                       obs_cyc, o_vld, o_data, e_data);
                end
            end
        end
    endtask

    task automatic test_violations();
        logic [DW-1:0] w;
        int beats, errs;
        drive_cycle(1'b0, '0, 2, 1'b1);
        drive_cycle(1'b0, '0, 0, 1'b1);
        checks++;
        if (o_err !== 1'b1 || o_vld !== 1'b0) begin
            errors++; $display("FAIL viol_orphan got err=%b vld=%b required err=1 vld=0", o_err, o_vld);
        end
        drive_cycle(1'b0, '0, 0, 1'b1);
        checks++;
        if (o_err !== 1'b0 || o_vld !== 1'b0) begin
            errors++; $display("FAIL viol_orphan_pulse got err=%b vld=%b required 0 0", o_err, o_vld);
        end
        w = {$urandom, $urandom};
        beats = 0; errs = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i == 0, w, (i == 1) ? 1 : 0, 1'b1);
            if (o_vld === 1'b1) beats++;
            if (o_err === 1'b1) errs++;
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL viol_missing_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
            if (e_vld) begin
                checks++;
                if (o_data[HW-1:0] !== w[HW-1:0]) begin
                    errors++; $display("FAIL viol_missing_data got %h required %h", o_data[HW-1:0], w[HW-1:0]);
                end
            end
        end
        checks++;
        if (beats != 1 || errs != 1) begin
            errors++; $display("FAIL viol_missing_count got beats=%0d errs=%0d required 1 1", beats, errs);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] wb;
        drive_cycle(1'b1, {$urandom, $urandom}, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 0, 1'b0);
        checks++;
        if (o_vld !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got vld=%b required 1", o_vld);
        end
        wb = {$urandom, $urandom};
        drive_cycle(1'b1, wb, 0, 1'b0);
        bus.in_vld  = {{CW{1'b1}}, {CW{1'b0}}};
        bus.in_data = {wb[DW-1:HW], {HW{1'b0}}};
        #2 a_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid_async got vld=%b rdy=%b required 0 1", bus.out_vld, bus.in_rdy[0]);
        end
        @(posedge clk);
        #3;
        bus.in_vld = '0;
        a_rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc += 2;
        drive_cycle(1'b0, '0, 2, 1'b1);
        checks++;
        if (o_vld !== 1'b0 || o_rdy0 !== 1'b1 || o_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_after got vld=%b rdy=%b err=%b required 0 1 0", o_vld, o_rdy0, o_err);
        end
        drive_cycle(1'b0, '0, 0, 1'b1);
        checks++;
        if (o_err !== 1'b1 || o_vld !== 1'b0) begin
            errors++; $display("FAIL rstmid_late_chunk got err=%b vld=%b required 1 0", o_err, o_vld);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            if (i < 300) drive_cycle($urandom_range(0, 9) < 7, {$urandom, $urandom}, 0, $urandom_range(0, 9) < 6);
            else         drive_cycle(1'b0, '0, 0, 1'b1);
            checks++;
            if ({o_rdy0, o_vld, o_err} !== {e_rdy0, e_vld, e_err}) begin
                errors++; $display("FAIL rand_flags cyc=%0d got rdy/vld/err=%b required %b",
                                   obs_cyc, {o_rdy0, o_vld, o_err}, {e_rdy0, e_vld, e_err});
            end
            if (e_vld) begin
                checks++;
                if (o_data !== e_data) begin
                    errors++; $display("FAIL rand_data cyc=%0d got %h required %h", obs_cyc, o_data, e_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_pop_full();
        test_violations();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
